// File: rtl/debug_uart_sched.sv
// rtl/debug_uart_sched.sv - shares the debug uart_tx between a CPU byte FIFO and a trace holding register
module debug_uart_sched #(
  parameter int DEPTH         = 4,
  parameter int LW            = 3,
  parameter int START_TIMEOUT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_wr,
  input  logic [7:0]    cpu_data,
  output logic          cpu_full,
  output logic          cpu_ovf,
  input  logic          ovf_clr,
  input  logic          trace_valid,
  input  logic [7:0]    trace_data,
  output logic          trace_ready,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  input  logic          tx_busy,
  output logic [LW-1:0] fifo_level,
  output logic          grant_trace
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  // CPU FIFO storage; pointers wrap naturally because DEPTH is a power of two
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  // Trace holding register
  logic          hold_full;
  logic [7:0]    hold_data;

  // 1 = trace source won the previous launch
  logic          last_grant;
  logic [TW-1:0] start_cnt;

  logic          launch;
  logic          sel_trace;
  logic          cpu_pend;
  logic          pop;
  logic          push;
  logic          drop;
  logic [7:0]    sel_byte;

  assign cpu_pend    = (level != '0);
  assign cpu_full    = (level == LW'(DEPTH));
  assign trace_ready = !hold_full;
  assign fifo_level  = level;
  assign pop         = launch && !sel_trace;
  // A pop in the same cycle makes room, so a full FIFO can still accept
  assign push        = cpu_wr && (!cpu_full || pop);
  assign drop        = cpu_wr && !push;
  assign sel_byte    = sel_trace ? hold_data : mem[rd_ptr];

  // Next-state logic: arbitration and launch decision happen only in IDLE
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    sel_trace  = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && (cpu_pend || hold_full)) begin
          launch     = 1'b1;
          sel_trace  = (cpu_pend && hold_full) ? !last_grant : hold_full;
          state_next = START;
        end
      end
      START: begin
        if (tx_busy || (start_cnt == TW'(START_TIMEOUT - 1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!tx_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and START dwell counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_cnt <= '0;
    end else begin
      state     <= state_next;
      start_cnt <= (state == START && state_next == START) ? start_cnt + TW'(1) : '0;
    end
  end

  // Registered launch strobe, byte and grant bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      grant_trace <= 1'b0;
      last_grant  <= 1'b1;
    end else begin
      tx_en <= launch;
      if (launch) begin
        tx_data     <= sel_byte;
        grant_trace <= sel_trace;
        last_grant  <= sel_trace;
      end
    end
  end

  // FIFO data write; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cpu_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ovf <= 1'b0;
    end else if (drop) begin
      cpu_ovf <= 1'b1;
    end else if (ovf_clr) begin
      cpu_ovf <= 1'b0;
    end
  end

  // Trace holding register: capture on handshake, free on launch
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
    end else if (trace_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= trace_data;
    end else if (launch && sel_trace) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_uart_sched.sv
// tb/tb_debug_uart_sched.sv - directed self-checking bench for debug_uart_sched
module tb_debug_uart_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_wr;
  logic [7:0] cpu_data;
  logic       cpu_full;
  logic       cpu_ovf;
  logic       ovf_clr;
  logic       trace_valid;
  logic [7:0] trace_data;
  logic       trace_ready;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [2:0] fifo_level;
  logic       grant_trace;

  int tests  = 0;
  int failed = 0;

  debug_uart_sched #(.DEPTH(4), .LW(3), .START_TIMEOUT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_wr      (cpu_wr),
    .cpu_data    (cpu_data),
    .cpu_full    (cpu_full),
    .cpu_ovf     (cpu_ovf),
    .ovf_clr     (ovf_clr),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trace_ready (trace_ready),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .grant_trace (grant_trace)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_wr = 1'b0; cpu_data = 8'h00; ovf_clr = 1'b0;
    trace_valid = 1'b0; trace_data = 8'h00; tx_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    cpu_wr = 1'b1; cpu_data = b;
    step();
    cpu_wr = 1'b0;
  endtask

  task automatic frame();
    tx_busy = 1'b1;
    step();
    step();
    tx_busy = 1'b0;
    step();
  endtask

  task automatic wait_launch(input logic [7:0] b, input logic g);
    for (int i = 0; i < 20 && tx_en !== 1'b1; i++) step();
    chk("launch_seen", tx_en, 1);
    chk("launch_data", tx_data, b);
    chk("launch_grant", grant_trace, g);
  endtask

  initial begin
    // reset state and single CPU byte latency
    do_reset();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_trace_ready", trace_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", cpu_ovf, 0);
    chk("rst_grant", grant_trace, 0);
    push(8'h41);
    chk("lat_n1_tx_en", tx_en, 0);
    chk("lat_n1_level", fifo_level, 1);
    step();
    chk("lat_n2_tx_en", tx_en, 1);
    chk("lat_n2_data", tx_data, 8'h41);
    step();
    chk("pulse_one_cycle", tx_en, 0);
    frame();

    // overflow while busy, in-order drain, overflow clear
    do_reset();
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    chk("ovf_level", fifo_level, 4);
    chk("ovf_full", cpu_full, 1);
    chk("ovf_flag", cpu_ovf, 1);
    chk("ovf_no_launch", tx_en, 0);
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_launch(8'h10 + 8'(i), 1'b0);
      frame();
    end
    chk("drain_level", fifo_level, 0);
    chk("drain_no_0x14", tx_en, 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", cpu_ovf, 0);

    // push and pop on a full FIFO in the same cycle
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    chk("full_before", cpu_full, 1);
    cpu_wr = 1'b1; cpu_data = 8'h24; tx_busy = 1'b0;
    step();
    cpu_wr = 1'b0;
    chk("pp_full_tx_en", tx_en, 1);
    chk("pp_full_data", tx_data, 8'h20);
    chk("pp_full_level", fifo_level, 4);
    chk("pp_full_no_ovf", cpu_ovf, 0);
    frame();
    for (int i = 1; i < 5; i++) begin
      wait_launch(8'h20 + 8'(i), 1'b0);
      frame();
    end

    // round-robin between CPU and trace
    do_reset();
    tx_busy = 1'b1;
    push(8'hA0);
    push(8'hA1);
    trace_valid = 1'b1; trace_data = 8'h55;
    step();
    trace_data = 8'h56;
    chk("rr_hold_taken", trace_ready, 0);
    tx_busy = 1'b0;
    wait_launch(8'hA0, 1'b0);
    frame();
    wait_launch(8'h55, 1'b1);
    chk("rr_ready_after_launch", trace_ready, 1);
    step();
    trace_valid = 1'b0;
    chk("rr_56_taken", trace_ready, 0);
    frame();
    wait_launch(8'hA1, 1'b0);
    frame();
    wait_launch(8'h56, 1'b1);
    frame();

    // trace valid held high while UART busy
    do_reset();
    tx_busy = 1'b1;
    trace_valid = 1'b1; trace_data = 8'h61;
    step();
    trace_data = 8'h62;
    chk("tv_captured", trace_ready, 0);
    step();
    step();
    chk("tv_still_held", trace_ready, 0);
    chk("tv_no_launch", tx_en, 0);
    tx_busy = 1'b0;
    wait_launch(8'h61, 1'b1);
    chk("tv_ready_launch_plus1", trace_ready, 1);
    step();
    trace_valid = 1'b0;
    chk("tv_second_captured", trace_ready, 0);
    frame();
    wait_launch(8'h62, 1'b1);
    frame();

    // tx_busy never rises: START times out
    do_reset();
    cpu_wr = 1'b1; cpu_data = 8'h71;
    step();
    cpu_data = 8'h72;
    step();
    cpu_wr = 1'b0;
    chk("to_first_launch", tx_en, 1);
    chk("to_first_data", tx_data, 8'h71);
    chk("to_level_pushpop", fifo_level, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_gap_low", tx_en, 0);
    end
    step();
    chk("to_second_launch", tx_en, 1);
    chk("to_second_data", tx_data, 8'h72);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_no_double", tx_en, 0);
    end

    // reset in DONE with two bytes queued
    do_reset();
    push(8'h81);
    step();
    chk("rd_launch", tx_en, 1);
    tx_busy = 1'b1;
    step();
    push(8'h82);
    push(8'h83);
    chk("rd_queued", fifo_level, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rd_level", fifo_level, 0);
    chk("rd_tx_en", tx_en, 0);
    chk("rd_trace_ready", trace_ready, 1);
    chk("rd_full", cpu_full, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_no_launch_busy", tx_en, 0);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rd_no_launch_idle", tx_en, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/debug_uart_sched.md
Name: debug_uart_sched

Overview:
- Shares the single debug UART transmitter (uart_tx, 4 Mbaud) between two byte sources: CPU writes to the debug UART data register, and a hardware trace source streaming debug event bytes.
- Sits between the top-level peripheral decode and the uart_tx instance. Replaces the direct tx_start/data_to_write connection.
- CPU bytes are buffered in a small FIFO. Trace bytes use a valid/ready holding register.
- Round-robin arbitration and a launch/complete FSM sequence one byte per UART frame.

Parameters:
- DEPTH, 4, CPU FIFO depth in bytes; power of two, 2..16.
- LW, 3, width of fifo_level; must satisfy 2^LW > DEPTH.
- START_TIMEOUT, 3, cycles to wait for tx_busy to rise after a launch before treating the launch as taken.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- cpu_wr  in  1  one-cycle strobe; CPU write to debug UART data register
- cpu_data  in  8  byte written by CPU
- cpu_full  out  1  FIFO full (drives UART status bit 0 read-back)
- cpu_ovf  out  1  sticky overflow flag: a CPU byte was dropped
- ovf_clr  in  1  clears cpu_ovf
- trace_valid  in  1  trace byte offered
- trace_data  in  8  trace byte
- trace_ready  out  1  holding register empty; handshake completes when valid&&ready
- tx_en  out  1  launch strobe to uart_tx, registered
- tx_data  out  8  byte to uart_tx, registered, stable while tx_en=1
- tx_busy  in  1  uart_tx busy
- fifo_level  out  LW  CPU FIFO occupancy, 0..DEPTH
- grant_trace  out  1  1 when the byte in flight came from the trace source

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - tx_en=0, tx_data=0, cpu_ovf=0, fifo_level=0, grant_trace=0.
  - Trace holding register empty, so trace_ready=1.
  - FSM in IDLE; last_grant=TRACE, so the CPU wins the first tie.
- Reset mid-frame: the FIFO and holding register are flushed and any pending byte is lost. The FSM returns to IDLE without waiting for tx_busy.
- CPU FIFO push:
  - cpu_wr is accepted when fifo_level<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and cpu_ovf is set the next cycle.
  - ovf_clr clears cpu_ovf; a set in the same cycle wins.
  - cpu_full = (fifo_level==DEPTH), combinational from the registered level.
  - Pointers wrap modulo DEPTH.
- Trace handshake:
  - trace_ready = holding register empty.
  - On valid&&ready the byte is captured and trace_ready drops the next cycle.
  - The register is freed when the trace byte is launched; trace_ready rises the cycle after the launch.
- FSM states:
  - IDLE:
    - If tx_busy=0 and a source is pending (FIFO non-empty or holding register full), select it.
    - If both are pending, select the source not equal to last_grant.
    - Register tx_en=1 and tx_data=selected byte. Pop the FIFO or free the holding register.
    - Update last_grant and grant_trace, then go to START.
  - START:
    - tx_en returns to 0 (exactly one-cycle pulse).
    - Go to DONE when tx_busy=1, or after START_TIMEOUT cycles in START.
  - DONE:
    - Stay while tx_busy=1. Go to IDLE when tx_busy=0.
- Timing:
  - Latency from a cpu_wr into an empty FIFO with an idle UART to tx_en=1 is 2 cycles.
  - The minimum gap between launches is one IDLE cycle after tx_busy falls.
- No byte is ever launched while tx_busy=1. At most one byte is in flight.
- Simultaneous push and pop on a full FIFO leaves fifo_level=DEPTH and the push succeeds.
- A push and pop in the same cycle on a non-full FIFO leaves fifo_level unchanged.

Test Plan:
- Reset with both sources idle -> tx_en=0, trace_ready=1, fifo_level=0, cpu_ovf=0. Then cpu_wr 0x41 at cycle N with the UART model idle -> tx_en=1, tx_data=0x41 at cycle N+2 for exactly 1 cycle.
- Five cpu_wr strobes (0x10..0x14) back-to-back while tx_busy is held high -> fifo_level=4, cpu_full=1, 0x14 dropped, cpu_ovf=1. Release busy -> 0x10..0x13 emitted in order. ovf_clr -> cpu_ovf=0.
- FIFO holds 0xA0,0xA1 and trace offers 0x55 then 0x56 -> launch order 0xA0, 0x55, 0xA1, 0x56, with grant_trace toggling 0,1,0,1.
- Trace valid held high with tx_busy high -> first byte captured, trace_ready=0 until that byte's launch cycle+1, second byte not taken early.
- tx_busy never rises after a launch -> FSM leaves START after 3 cycles, returns to IDLE, and the next byte launches. No double launch of the same byte.
- rst asserted in DONE with 2 bytes queued -> next cycle fifo_level=0, tx_en=0, trace_ready=1, FSM IDLE. No launch follows even while tx_busy stays high.
